dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's MEM-stage load/store port.
- Replaces the zero-latency data memory with a word array behind a request/response handshake with configurable wait states.
- Drives a stall back to the pipeline until each access completes.
- Sits between the EX/MEM register outputs (request) and the MEM/WB register inputs (read data), with stall fanning out to every pipeline register load.

Parameters:
- WAIT_CYCLES, 2, wait-state cycles between accept and response (0..15)
- ADDR_W, 8, byte-address width of the request
- DEPTH, 64, number of 32-bit words stored; must be <= 2**(ADDR_W-2)

Ports:
- clk  in  1  clock
- clr  in  1  reset; synchronous and active-high, sampled on rising clk
- req_rd  in  1  load request (MEM-stage mem_read)
- req_wr  in  1  store request (MEM-stage mem_write)
- req_addr  in  ADDR_W  byte address (ALU result)
- req_wdata  in  32  store data
- stall  out  1  hold all pipeline registers this cycle
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  load data, held until next completion
- rsp_err  out  1  error flag, qualified by rsp_valid

Behaviour:
- req_valid = req_rd | req_wr. The requester holds req_* stable while stall=1.
- stall = req_valid & ~rsp_valid (combinational). No stall when idle with no request.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On req_valid: capture rd/wr/addr/wdata and load cnt=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - cnt decrements each cycle; at cnt==1 go to RESP.
  - If req_valid drops (pipeline flush): abort to IDLE, no write, no rsp_valid.
- RESP:
  - rsp_valid=1 for exactly one cycle; next state is always IDLE.
  - The request seen in IDLE on the next cycle is the following instruction's.
- Latency: accept in cycle 0, rsp_valid in cycle WAIT_CYCLES+1. Back-to-back accesses therefore take WAIT_CYCLES+2 cycles each.
- Read: array read at the edge entering RESP. rsp_rdata registered and held until the next rsp_valid.
- Write: array written at the rising edge that ends the RESP cycle. rsp_rdata is unchanged on writes.
- Error (rsp_err=1 with rsp_valid) in any of these cases:
  - req_addr[1:0] != 0 (misaligned)
  - word index req_addr[ADDR_W-1:2] >= DEPTH (out of range)
  - req_rd & req_wr both high
- On error: the write is suppressed and rsp_rdata is set to 0.
- Word index is req_addr[ADDR_W-1:2]; bits [1:0] are never used for indexing.
- Reset (clr=1):
  - State goes to IDLE, cnt=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - Any pending write is dropped.
  - Array contents are NOT cleared.
  - stall follows its combinational equation during reset.
- Reset mid-WAIT or in RESP: no write occurs, no rsp_valid. If the request is still held after reset, it restarts from IDLE.
- Array has no reset. Simulation preload comes from a hex file via the sub-module.

Decomposition:
- Shared package:
  - state enum (IDLE/WAIT/RESP), 2-bit
  - WORD_W=32
  - counter width constant CNT_W=4
- Sub-module dmem_array:
  - DEPTH x 32, single port, synchronous write enable, registered read.
  - Parameters DEPTH and init file.
- Responder top: FSM, counter, capture registers, error check, stall.

Test Plan:
- Store 0xDEADBEEF to addr 0x10, then load 0x10, WAIT_CYCLES=2:
  - Each access shows stall high 3 cycles, rsp_valid in cycle 3.
  - The load returns rsp_rdata=0xDEADBEEF, rsp_err=0.
- WAIT_CYCLES=0: load of preloaded word 3 (addr 0x0C) completes with rsp_valid in cycle 1; stall high for 1 cycle only.
- Misaligned store to 0x11 with data 0x12345678:
  - rsp_err=1, rsp_rdata=0.
  - A subsequent load of 0x10 returns the old value (no write).
- req_rd=req_wr=1 at 0x20: rsp_err=1 and word 8 is unchanged. Addr 0x100-equivalent out of range (DEPTH=32, addr 0x80): rsp_err=1.
- Flush: drop req_valid during WAIT (store 0xAAAA5555 to 0x04):
  - FSM returns to IDLE, no rsp_valid.
  - A later load of 0x04 returns the original contents.
- clr asserted during WAIT of a store:
  - After reset, outputs are all zero and the store is not performed.
  - Preloaded array data survives; the held request restarts and completes WAIT_CYCLES+1 cycles after clr drops.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package dmem_responder_pkg;

   localparam int WORD_W = 32;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port word store: synchronous write enable, registered read data.
module dmem_array
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] rdata_q;

   // NOTE: storage arrays take no reset, so contents survive clr and the
   // block maps onto plain RAM instead of a wall of resettable flops.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: accepts one access, inserts WAIT_CYCLES wait states,
// then pulses rsp_valid while stalling the pipeline until completion.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 64
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              req_rd,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              stall,
   output logic              rsp_valid,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int IDX_W = ADDR_W - 2;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              zero_q, zero_d;
   logic              cap_rd_q, cap_wr_q;
   logic [ADDR_W-1:0] cap_addr_q;
   logic [WORD_W-1:0] cap_wdata_q;

   logic              req_valid;
   logic              cur_rd, cur_wr;
   logic [ADDR_W-1:0] cur_addr;
   logic [IDX_W-1:0]  cur_idx;
   logic              cur_err;
   logic              enter_resp;
   logic              arr_we, arr_re;
   logic [AW-1:0]     arr_addr;
   logic [WORD_W-1:0] arr_rdata;

   assign req_valid = req_rd | req_wr;
   assign rsp_valid = (state_q == RESP);
   assign stall     = req_valid & ~rsp_valid;
   assign rsp_err   = rsp_valid & err_q;
   assign rsp_rdata = zero_q ? '0 : arr_rdata;

   // With zero wait states RESP is entered on the accept edge itself, so the
   // live request stands in for the not-yet-captured copy while in IDLE.
   always_comb begin
      if (state_q == IDLE) begin
         cur_rd   = req_rd;
         cur_wr   = req_wr;
         cur_addr = req_addr;
      end else begin
         cur_rd   = cap_rd_q;
         cur_wr   = cap_wr_q;
         cur_addr = cap_addr_q;
      end
   end

   assign cur_idx = cur_addr[ADDR_W-1:2];
   assign cur_err = (cur_addr[1:0] != 2'b00)
                 || ({1'b0, cur_idx} >= (IDX_W+1)'(DEPTH))
                 || (cur_rd && cur_wr);

   // NOTE: every signal assigned here gets its default first, so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               cnt_d   = WAIT_INIT;
               state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (!req_valid) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state_d = RESP;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign enter_resp = (state_d == RESP) && !clr;
   assign arr_re     = enter_resp && cur_rd && !cur_err;
   assign arr_we     = rsp_valid && cap_wr_q && !err_q && !clr;
   assign arr_addr   = rsp_valid ? cap_addr_q[AW+1:2] : cur_addr[AW+1:2];

   // Read data shows zero after reset or an error; a good store leaves the
   // previously returned load data in place.
   always_comb begin
      err_d  = err_q;
      zero_d = zero_q;
      if (enter_resp) begin
         err_d = cur_err;
         if (cur_err) begin
            zero_d = 1'b1;
         end else if (cur_rd) begin
            zero_d = 1'b0;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         zero_q  <= zero_d;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == IDLE && req_valid) begin
         cap_rd_q    <= req_rd;
         cap_wr_q    <= req_wr;
         cap_addr_q  <= req_addr;
         cap_wdata_q <= req_wdata;
      end
   end

   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .we_i    (arr_we),
      .re_i    (arr_re),
      .addr_i  (arr_addr),
      .wdata_i (cap_wdata_q),
      .rdata_o (arr_rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: instance 0 has 2 wait states and 32 words, instance 1 has
// none and 64 words; a reference model predicts every completion.
module tb_dmem_responder;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        clr   [2];
   logic        rd    [2];
   logic        wr    [2];
   logic [7:0]  addr  [2];
   logic [31:0] wdata [2];
   logic        stall [2];
   logic        rv    [2];
   logic [31:0] rdata [2];
   logic        err   [2];

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_m  [2][64];
   logic [31:0] last_m [2];
   exp_t        sb0 [$];
   exp_t        sb1 [$];

   always #5 clk = ~clk;

   dmem_responder #(.WAIT_CYCLES(2), .ADDR_W(8), .DEPTH(32)) u_dut0 (
      .clk(clk), .clr(clr[0]), .req_rd(rd[0]), .req_wr(wr[0]),
      .req_addr(addr[0]), .req_wdata(wdata[0]), .stall(stall[0]),
      .rsp_valid(rv[0]), .rsp_rdata(rdata[0]), .rsp_err(err[0])
   );

   dmem_responder #(.WAIT_CYCLES(0), .ADDR_W(8), .DEPTH(64)) u_dut1 (
      .clk(clk), .clr(clr[1]), .req_rd(rd[1]), .req_wr(wr[1]),
      .req_addr(addr[1]), .req_wdata(wdata[1]), .stall(stall[1]),
      .rsp_valid(rv[1]), .rsp_rdata(rdata[1]), .rsp_err(err[1])
   );

   function automatic int wait_of(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   function automatic int depth_of(input int i);
      return (i == 0) ? 32 : 64;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference behaviour: a word-addressed array plus "last load data" register.
   task automatic model_push(input int i, input logic r, input logic w,
                             input logic [7:0] a, input logic [31:0] d);
      exp_t e;
      int   idx;
      idx = int'(a) / 4;
      if ((int'(a) % 4) != 0 || idx >= depth_of(i) || (r && w)) begin
         e.err = 1'b1; e.rdata = 32'h0; last_m[i] = 32'h0;
      end else if (r) begin
         e.err = 1'b0; e.rdata = mem_m[i][idx]; last_m[i] = e.rdata;
      end else begin
         e.err = 1'b0; e.rdata = last_m[i]; mem_m[i][idx] = d;
      end
      if (i == 0) sb0.push_back(e); else sb1.push_back(e);
   endtask

   // Called at posedge+1 with the request already driven; ends at posedge+1
   // with the request removed.
   task automatic wait_rsp(input int i);
      int k, st;
      bit done;
      k = 0; st = 0; done = 0;
      while (!done && k < 40) begin
         @(negedge clk);
         if (stall[i]) st++;
         if (rv[i]) done = 1; else k++;
      end
      check($sformatf("latency[%0d]", i), 32'(k), 32'(wait_of(i) + 1));
      check($sformatf("stall_cycles[%0d]", i), 32'(st), 32'(wait_of(i) + 1));
      @(posedge clk); #1;
      rd[i] = 1'b0; wr[i] = 1'b0;
   endtask

   task automatic access(input int i, input logic r, input logic w,
                         input logic [7:0] a, input logic [31:0] d);
      model_push(i, r, w, a, d);
      rd[i] = r; wr[i] = w; addr[i] = a; wdata[i] = d;
      wait_rsp(i);
   endtask

   task automatic check_idle_outputs(input int i, input logic exp_stall, input string tag);
      check({tag, "_rsp_valid"}, 32'(rv[i]), 32'(0));
      check({tag, "_rsp_err"}, 32'(err[i]), 32'(0));
      check({tag, "_rsp_rdata"}, rdata[i], 32'h0);
      check({tag, "_stall"}, 32'(stall[i]), 32'(exp_stall));
   endtask

   // Monitor: every completion must match the oldest outstanding prediction.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rv[i] === 1'b1) begin
            if ((i == 0 ? sb0.size() : sb1.size()) == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp[%0d]: rsp_valid=1, expected no response (t=%0t)", i, $time);
            end else begin
               exp_t e;
               if (i == 0) e = sb0.pop_front(); else e = sb1.pop_front();
               check($sformatf("rsp_err[%0d]", i), 32'(err[i]), 32'(e.err));
               check($sformatf("rsp_rdata[%0d]", i), rdata[i], e.rdata);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         clr[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0;
         addr[i] = '0; wdata[i] = '0; last_m[i] = 32'h0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs(0, 1'b0, "reset0");
      check_idle_outputs(1, 1'b0, "reset1");
      @(posedge clk); #1;
      clr[0] = 1'b0; clr[1] = 1'b0;

      // Known contents for every word of both arrays.
      for (int i = 0; i < 2; i++)
         for (int w = 0; w < depth_of(i); w++)
            access(i, 1'b0, 1'b1, 8'(w * 4), $urandom);

      access(0, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
      access(0, 1'b1, 1'b0, 8'h10, 32'h0);
      access(0, 1'b0, 1'b1, 8'h11, 32'h12345678);
      access(0, 1'b1, 1'b0, 8'h10, 32'h0);
      access(0, 1'b1, 1'b1, 8'h20, 32'h55AA55AA);
      access(0, 1'b1, 1'b0, 8'h20, 32'h0);
      access(0, 1'b1, 1'b0, 8'h80, 32'h0);
      access(0, 1'b0, 1'b1, 8'h7C, 32'h01020304);
      access(0, 1'b1, 1'b0, 8'h7C, 32'h0);

      // Flush: request removed during the wait states.
      rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 8'h04; wdata[0] = 32'hAAAA5555;
      @(negedge clk); @(negedge clk);
      @(posedge clk); #1;
      wr[0] = 1'b0;
      @(negedge clk);
      check("flush_stall", 32'(stall[0]), 32'(0));
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
      access(0, 1'b1, 1'b0, 8'h04, 32'h0);

      // Reset mid-wait with the store then withdrawn: nothing is written.
      rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 8'h18; wdata[0] = 32'h0BADF00D;
      @(negedge clk); @(negedge clk);
      @(posedge clk); #1;
      clr[0] = 1'b1;
      @(posedge clk); #1;
      clr[0] = 1'b0; wr[0] = 1'b0; last_m[0] = 32'h0;
      @(negedge clk);
      check_idle_outputs(0, 1'b0, "clr_drop");
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      access(0, 1'b1, 1'b0, 8'h18, 32'h0);

      // Reset mid-wait with the store held: it restarts once clr drops.
      rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 8'h1C; wdata[0] = 32'hCAFEF00D;
      @(negedge clk); @(negedge clk);
      @(posedge clk); #1;
      clr[0] = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check_idle_outputs(0, 1'b1, "clr_hold");
      @(posedge clk); #1;
      clr[0] = 1'b0;
      last_m[0] = 32'h0;
      model_push(0, 1'b0, 1'b1, 8'h1C, 32'hCAFEF00D);
      wait_rsp(0);
      access(0, 1'b1, 1'b0, 8'h1C, 32'h0);
      access(0, 1'b1, 1'b0, 8'h10, 32'h0);

      // Zero wait states.
      access(1, 1'b1, 1'b0, 8'h0C, 32'h0);
      access(1, 1'b1, 1'b0, 8'h0E, 32'h0);
      access(1, 1'b0, 1'b1, 8'hFC, 32'h89ABCDEF);
      access(1, 1'b1, 1'b0, 8'hFC, 32'h0);

      for (int n = 0; n < 300; n++) begin
         int          i, kind;
         logic [7:0]  a;
         i    = n % 2;
         kind = $urandom_range(0, 9);
         a    = 8'($urandom_range(0, (i == 0) ? 39 : 63) * 4);
         if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
         access(i, (kind <= 4) || (kind == 9), (kind >= 5), a, $urandom);
      end

      repeat (3) @(negedge clk);
      check("sb0_drained", 32'(sb0.size()), 32'(0));
      check("sb1_drained", 32'(sb1.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
